// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and queue entry layout for the ALU issue controller
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        INC  = 4'd1,
        SUB  = 4'd2,
        DEC  = 4'd3,
        MUL  = 4'd4,
        DIV  = 4'd5,
        SHL  = 4'd6,
        SHR  = 4'd7,
        INV  = 4'd8,
        AND  = 4'd9,
        OR   = 4'd10,
        NAND = 4'd11,
        NOR  = 4'd12,
        XOR  = 4'd13,
        XNOR = 4'd14,
        BUF  = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int ENTRY_W = 20;

    typedef struct packed {
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    function automatic logic is_div_zero(input op_t op);
        return (op.cmd == DIV) && (op.b == 8'd0);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - operation queue, DEPTH entries, full/empty flags
module op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer wrap falls out of the adder width
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - queues ALU operations, issues one per EXEC cycle, holds results until accepted
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [3:0]  req_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_cmd,
    output logic        alu_en,
    input  logic [15:0] alu_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_cmd,
    output logic        rsp_err,
    output logic [15:0] op_count
);

    state_e      state_q, state_d;
    op_t         op_q, op_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_cmd_q, rsp_cmd_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] op_count_q, op_count_d;

    op_t  fifo_wdata;
    op_t  fifo_rdata;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic fifo_push;

    assign req_ready  = !fifo_full && !rst;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_wdata = '{cmd: req_cmd, a: req_a, b: req_b};

    op_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_op_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The operand register feeds the ALU directly, so the ALU inputs hold outside EXEC
    assign alu_a     = op_q.a;
    assign alu_b     = op_q.b;
    assign alu_cmd   = op_q.cmd;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cmd   = rsp_cmd_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_cmd_d   = rsp_cmd_q;
        rsp_err_d   = rsp_err_q;
        op_count_d  = op_count_q;
        fifo_pop    = 1'b0;
        alu_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_rdata;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                alu_en      = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_cmd_d   = op_q.cmd;
                rsp_err_d   = is_div_zero(op_q);
                rsp_data_d  = is_div_zero(op_q) ? 16'h0000 : alu_y;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 16'd1;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        op_d     = fifo_rdata;
                        state_d  = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cmd_q   <= '0;
            rsp_err_q   <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cmd_q   <= rsp_cmd_d;
            rsp_err_q   <= rsp_err_d;
            op_count_q  <= op_count_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a reference ALU
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_a = '0;
    logic [7:0]  req_b = '0;
    logic [3:0]  req_cmd = '0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_en;
    logic [15:0] alu_y;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_cmd;
    logic        rsp_err;
    logic [15:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;
    logic [19:0] sb[$];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cmd   (req_cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .alu_en    (alu_en),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_cmd   (rsp_cmd),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    // Divide by zero returns all ones so the controller's override is visible
    function automatic logic [15:0] alu_model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] xa;
        logic [15:0] xb;
        xa = {8'h00, a};
        xb = {8'h00, b};
        case (c)
            4'd0:    return xa + xb;
            4'd1:    return xa + 16'd1;
            4'd2:    return xa - xb;
            4'd3:    return xa - 16'd1;
            4'd4:    return xa * xb;
            4'd5:    return (b == 8'd0) ? 16'hFFFF : xa / xb;
            4'd6:    return xa << b[2:0];
            4'd7:    return xa >> b[2:0];
            4'd8:    return {8'h00, ~a};
            4'd9:    return {8'h00, a & b};
            4'd10:   return {8'h00, a | b};
            4'd11:   return {8'h00, ~(a & b)};
            4'd12:   return {8'h00, ~(a | b)};
            4'd13:   return {8'h00, a ^ b};
            4'd14:   return {8'h00, ~(a ^ b)};
            default: return xa;
        endcase
    endfunction

    assign alu_y = alu_model(alu_cmd, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_cmd   = c;
        req_a     = a;
        req_b     = b;
        for (int i = 0; i < 40 && !done; i++) begin
            if (req_ready) done = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        if (!rsp_valid) chk("wait_rsp_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done      = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (sb.size() == 0 && !rsp_valid && !alu_en) done = 1'b1;
            else tick();
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    // Scoreboard: record accepted requests, compare every consumed response in order
    always @(negedge clk) begin
        logic [19:0] e;
        logic        e_err;
        if (!rst) begin
            if (req_valid && req_ready) sb.push_back({req_cmd, req_a, req_b});
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e     = sb.pop_front();
                    e_err = (e[19:16] == 4'd5) && (e[7:0] == 8'd0);
                    chk("sb_rsp_data", rsp_data, e_err ? 16'h0000 : alu_model(e[19:16], e[15:8], e[7:0]));
                    chk("sb_rsp_cmd", rsp_cmd, e[19:16]);
                    chk("sb_rsp_err", rsp_err, e_err);
                    exp_ops++;
                end
            end
        end
    end

    initial begin
        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_alu_a", alu_a, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_req_ready", req_ready, 1);

        // Single op: ADD 5,3
        req_valid = 1'b1;
        req_cmd   = ADD;
        req_a     = 8'd5;
        req_b     = 8'd3;
        tick();
        req_valid = 1'b0;
        chk("single_n_valid", rsp_valid, 0);
        chk("single_n_alu_en", alu_en, 0);
        tick();
        chk("single_n1_valid", rsp_valid, 0);
        chk("single_n1_alu_en", alu_en, 1);
        chk("single_n1_alu_a", alu_a, 8'd5);
        tick();
        chk("single_n2_valid", rsp_valid, 1);
        chk("single_n2_data", rsp_data, 16'd8);
        chk("single_n2_cmd", rsp_cmd, ADD);
        chk("single_n2_alu_en", alu_en, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("single_valid_drop", rsp_valid, 0);
        chk("single_op_count", op_count, 16'd1);

        // Fill: five accepted with the consumer stalled, sixth blocked
        push(ADD, 8'd1, 8'd2);
        push(SUB, 8'd10, 8'd4);
        push(MUL, 8'd7, 8'd6);
        push(XOR, 8'hF0, 8'h3C);
        push(SHL, 8'd1, 8'd3);
        chk("fill_req_ready", req_ready, 0);
        chk("fill_rsp_valid", rsp_valid, 1);
        chk("fill_head_data", rsp_data, 16'd3);
        chk("fill_head_cmd", rsp_cmd, ADD);
        req_valid = 1'b1;
        req_cmd   = DEC;
        req_a     = 8'd0;
        req_b     = 8'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fill_blocked", req_ready, 0);
        end
        rsp_ready = 1'b1;
        push(DEC, 8'd0, 8'd0);
        drain();
        rsp_ready = 1'b0;
        chk("fill_op_count", op_count, 16'd7);
        chk("fill_sb_count", exp_ops, 7);

        // Divide by zero then a normal divide
        push(DIV, 8'd9, 8'd0);
        wait_rsp();
        chk("div0_err", rsp_err, 1);
        chk("div0_data", rsp_data, 16'h0000);
        chk("div0_cmd", rsp_cmd, DIV);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        push(DIV, 8'd9, 8'd3);
        wait_rsp();
        chk("div3_err", rsp_err, 0);
        chk("div3_data", rsp_data, 16'd3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Backpressure: MUL 12,11 held for five cycles
        push(MUL, 8'd12, 8'd11);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 16'd132);
            chk("bp_cmd", rsp_cmd, MUL);
            chk("bp_alu_en", alu_en, 0);
            chk("bp_op_count", op_count, 16'd9);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_op_count_after", op_count, 16'd10);

        // Reset mid-op: one response consumed, EXEC with three queued
        for (int i = 0; i < 5; i++) push(ADD, 8'(i), 8'(i));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rmid_in_exec", alu_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_rsp_valid", rsp_valid, 0);
        chk("rmid_alu_en", alu_en, 0);
        chk("rmid_alu_a", alu_a, 0);
        chk("rmid_alu_cmd", alu_cmd, 0);
        chk("rmid_rsp_data", rsp_data, 0);
        chk("rmid_op_count", op_count, 0);
        chk("rmid_req_ready", req_ready, 0);
        sb.delete();
        exp_ops = 0;
        tick();
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rmid_no_stale", rsp_valid, 0);
        end
        chk("rmid_op_count_after", op_count, 0);
        chk("rmid_req_ready_after", req_ready, 1);

        // Sweep all opcodes over a,b in 0..15
        for (int c = 0; c < 16; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    push(4'(c), 8'(a), 8'(b));
        drain();
        chk("sweep_op_count", op_count, 16'd4096);
        chk("sweep_sb_count", exp_ops, 4096);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: DEPTH, default 4, operation queue depth (power of two, >=2).
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req_valid  in  1  operation request present.
REQ-005 Port: req_ready  out  1  queue can accept a request.
REQ-006 Port: req_a, req_b  in  8 each  operands.
REQ-007 Port: req_cmd  in  4  ALU opcode.
REQ-008 Port: alu_a, alu_b  out  8 each  operands driven to the downstream ALU.
REQ-009 Port: alu_cmd  out  4  opcode driven to the ALU.
REQ-010 Port: alu_en  out  1  ALU enable.
REQ-011 Port: alu_y  in  16  combinational ALU result.
REQ-012 Port: rsp_valid  out  1  result available.
REQ-013 Port: rsp_ready  in  1  consumer accepts result.
REQ-014 Port: rsp_data  out  16  registered result.
REQ-015 Port: rsp_cmd  out  4  opcode of the result.
REQ-016 Port: rsp_err  out  1  divide-by-zero flag.
REQ-017 Port: op_count  out  16  completed-operation counter.

Function
REQ-018 req_ready SHALL equal "queue not full"; a request is accepted on the edge where req_valid && req_ready.
REQ-019 Queue SHALL be FIFO ordered; simultaneous push and pop SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.
REQ-020 FSM states: IDLE, EXEC, RESP.
REQ-021 IDLE: if queue non-empty, pop head into operand registers, go EXEC; else stay.
REQ-022 EXEC (one cycle): alu_en=1 with alu_a/alu_b/alu_cmd from operand registers; on the edge, capture alu_y into rsp_data, set rsp_valid=1, go RESP.
REQ-023 Outside EXEC, alu_en SHALL be 0 and alu_a/alu_b/alu_cmd SHALL hold their last values.
REQ-024 RESP: rsp_valid held with stable rsp_data/rsp_cmd/rsp_err until rsp_ready=1; on that edge rsp_valid drops, op_count increments (wrap 16'hFFFF->0), and the next state is EXEC with head popped if queue non-empty, else IDLE.
REQ-025 Latency: request accepted at edge N into an empty queue with FSM in IDLE -> rsp_valid high after edge N+2; sustained throughput one op per 2 cycles.
REQ-026 A request accepted in the same cycle the FSM evaluates an empty queue SHALL be popped on the following cycle, not the same cycle.
REQ-027 DIV with operand b==0: rsp_err=1 and rsp_data=16'h0000 regardless of alu_y; otherwise rsp_err=0 and rsp_data=alu_y.
REQ-028 rsp_cmd SHALL equal the opcode of the operation that produced rsp_data.

Reset
REQ-029 On rst assertion, immediately: queue emptied, FSM=IDLE, rsp_valid=0, rsp_data=0, rsp_cmd=0, rsp_err=0, alu_en=0, alu_a=alu_b=0, alu_cmd=0, op_count=0, req_ready=1 (if rst is low).
REQ-030 Reset mid-operation SHALL discard queued and in-flight operations without emitting a response.
REQ-031 req_ready SHALL be 0 while rst is high.

Structure
REQ-032 Opcode constants ADD=0..BUF=15 (ADD,INC,SUB,DEC,MUL,DIV,SHL,SHR,INV,AND,OR,NAND,NOR,XOR,XNOR,BUF) and FSM state encodings SHALL live in shared package alu_pkg.
REQ-033 The queue SHALL be a sub-module op_fifo (20-bit entries {cmd,a,b}, parameter DEPTH, full/empty outputs).

Verification
REQ-034 Single op: push a=8'd5,b=8'd3,cmd=ADD into idle block -> rsp_valid after 2 edges, rsp_data=alu_y (16'd8 with reference ALU), rsp_cmd=ADD, op_count=1.
REQ-035 Fill: hold rsp_ready=0, push 6 ops -> req_ready low once queue is full (DEPTH entries plus one in RESP); releasing rsp_ready returns results in push order.
REQ-036 Divide-by-zero: push a=8'd9,b=0,cmd=DIV -> rsp_err=1, rsp_data=16'h0000; following DIV a=8'd9,b=3 -> rsp_err=0.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles -> rsp_data/rsp_cmd stable, alu_en=0 throughout, op_count unchanged.
REQ-038 Reset mid-op: assert rst between clock edges during EXEC with 3 queued -> all outputs zero at once; after release no stale response, op_count=0.
REQ-039 Sweep: all 16 opcodes for a,b in 0..15 with rsp_ready=1 -> 256*16 responses, each matching the ALU model, op_count=16'd4096.
